// File: rtl/dds_ctrl_pkg.sv
// Shared state, mode and direction encodings for the DDS frequency-sweep sequencer.
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_CONT   = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; expire is a registered flag that is high in the
// last cycle of each max(dwell,1)-cycle dwell.
module dds_dwell_timer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (dwell == '0) ? DWELL_W'(1) : dwell;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  // expire is registered from the next count so it lines up with cnt_q == 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      expire <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      expire <= (cnt_d == DWELL_W'(1));
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word from f_start to f_stop
// in single, continuous-wrap or triangle mode with a programmable dwell.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned FTW_W   = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop_req,
  input  logic [1:0]         mode,
  input  logic [FTW_W-1:0]   f_start,
  input  logic [FTW_W-1:0]   f_stop,
  input  logic [FTW_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   ftw_out,
  output logic               dds_en,
  output logic               ftw_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [FTW_W-1:0]   ftw_d;
  logic               valid_d, busy_d, done_d, err_d;
  logic [1:0]         mode_q;
  logic [FTW_W-1:0]   fstart_q, fstop_q, fstep_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               accept_c, load_c, expire_c;
  logic [DWELL_W-1:0] dwell_sel_c;
  logic [FTW_W:0]     up_sum_c, dn_diff_c;
  logic [FTW_W-1:0]   up_val_c, dn_val_c;

  assign accept_c    = (state_q == IDLE) && start && (f_start <= f_stop);
  assign dwell_sel_c = accept_c ? dwell : dwell_q;

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .dwell  (dwell_sel_c),
    .expire (expire_c)
  );

  // Candidate next words, computed one bit wide to catch carry and borrow
  always_comb begin
    up_sum_c  = {1'b0, ftw_out} + {1'b0, fstep_q};
    dn_diff_c = {1'b0, ftw_out} - {1'b0, fstep_q};
    up_val_c  = (up_sum_c > {1'b0, fstop_q}) ? fstop_q : up_sum_c[FTW_W-1:0];
    dn_val_c  = (dn_diff_c[FTW_W] || (dn_diff_c[FTW_W-1:0] < fstart_q))
              ? fstart_q : dn_diff_c[FTW_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    ftw_d   = ftw_out;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = RUN;
          ftw_d   = f_start;
          dir_d   = DIR_UP;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      RUN: begin
        if (stop_req) begin
          state_d = FINISH;
        end else if (expire_c) begin
          if (dir_q == DIR_UP) begin
            if (ftw_out == fstop_q) begin
              case (mode_q)
                MODE_CONT: ftw_d = fstart_q;
                MODE_TRI: begin
                  dir_d = DIR_DOWN;
                  ftw_d = dn_val_c;
                end
                default:   state_d = FINISH;
              endcase
            end else if ((mode_q == MODE_SINGLE) && (fstep_q == '0)) begin
              state_d = FINISH;
            end else begin
              ftw_d = up_val_c;
            end
          end else if (ftw_out == fstart_q) begin
            dir_d = DIR_UP;
            ftw_d = up_val_c;
          end else begin
            ftw_d = dn_val_c;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load_c  = accept_c || ((state_q == RUN) && expire_c && (state_d == RUN));
    valid_d = accept_c || ((state_q == RUN) && (state_d == RUN) && (ftw_d != ftw_out));
    busy_d  = (state_d == RUN);
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      ftw_out   <= '0;
      ftw_valid <= 1'b0;
      busy      <= 1'b0;
      dds_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      ftw_out   <= ftw_d;
      ftw_valid <= valid_d;
      busy      <= busy_d;
      dds_en    <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Sweep configuration is frozen from the accepted start until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_SINGLE;
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      dwell_q  <= '0;
    end else if (accept_c) begin
      mode_q   <= (mode == 2'b11) ? MODE_SINGLE : mode;
      fstart_q <= f_start;
      fstop_q  <= f_stop;
      fstep_q  <= f_step;
      dwell_q  <= dwell;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: expected tuning words are queued at
// start and popped on every ftw_valid pulse.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop_req;
  logic [1:0]  mode;
  logic [7:0]  f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [7:0]  ftw_out;
  logic        dds_en, ftw_valid, busy, done, err;

  int checks;
  int errors;
  logic [7:0] sb[$];

  dds_sweep_ctrl #(.FTW_W(8), .DWELL_W(16)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .stop_req  (stop_req),
    .mode      (mode),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .ftw_out   (ftw_out),
    .dds_en    (dds_en),
    .ftw_valid (ftw_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then scramble the config inputs
  task automatic do_start(input logic [1:0] m, input logic [7:0] fs, input logic [7:0] fe,
                          input logic [7:0] st, input logic [15:0] dw);
    @(negedge clk);
    mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw; start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mode    = 2'($urandom);
    f_start = 8'($urandom);
    f_stop  = 8'($urandom);
    f_step  = 8'($urandom);
    dwell   = 16'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop_req = 1'b0; mode = 2'b00;
    f_start = 8'd0; f_stop = 8'd0; f_step = 8'd0; dwell = 16'd0;
    repeat (3) @(negedge clk);
    checks++; if (ftw_out !== 8'd0) begin errors++; $display("FAIL reset_ftw got=%0d exp=0", ftw_out); end
    checks++; if (dds_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", dds_en); end
    checks++; if (ftw_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ftw_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1'b1;
    @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_stop busy=%b done=%b exp=0/0", busy, done);
    end
  endtask

  // Cycle-exact model of a 10..40 step 10 dwell 3 single sweep
  task automatic test_single();
    logic [7:0] e_ftw;
    logic e_valid, e_busy, e_done;
    do_start(2'b00, 8'd10, 8'd40, 8'd10, 16'd3);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      e_ftw   = (c <= 12) ? 8'(10 + 10 * ((c - 1) / 3)) : 8'd40;
      e_valid = (c <= 12) && (((c - 1) % 3) == 0);
      e_busy  = (c <= 12);
      e_done  = (c == 13);
      checks++; if (ftw_out !== e_ftw) begin errors++; $display("FAIL single_ftw c=%0d got=%0d exp=%0d", c, ftw_out, e_ftw); end
      checks++; if (ftw_valid !== e_valid) begin errors++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, ftw_valid, e_valid); end
      checks++; if (busy !== e_busy || dds_en !== e_busy) begin
        errors++; $display("FAIL single_busy c=%0d busy=%b en=%b exp=%b", c, busy, dds_en, e_busy);
      end
      checks++; if (done !== e_done) begin errors++; $display("FAIL single_done c=%0d got=%b exp=%b", c, done, e_done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err c=%0d got=%b exp=0", c, err); end
      if (c == 5) begin
        f_start = 8'd200; f_stop = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_clamp();
    int n;
    bit seen_done;
    logic [7:0] e;
    sb.delete();
    sb.push_back(8'd10); sb.push_back(8'd20); sb.push_back(8'd30); sb.push_back(8'd35);
    do_start(2'b00, 8'd10, 8'd35, 8'd10, 16'd1);
    n = 0; seen_done = 1'b0;
    while (!seen_done && n < 40) begin
      @(negedge clk); n++;
      if (ftw_valid) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL clamp_extra got=%0d exp=none", ftw_out); end
        else begin
          e = sb.pop_front();
          if (ftw_out !== e) begin errors++; $display("FAIL clamp_ftw got=%0d exp=%0d", ftw_out, e); end
        end
      end
      checks++; if (ftw_out > 8'd35) begin errors++; $display("FAIL clamp_max got=%0d exp<=35", ftw_out); end
      if (done) seen_done = 1'b1;
    end
    checks++; if (!seen_done || n != 5) begin errors++; $display("FAIL clamp_done cycle=%0d seen=%b exp=5", n, seen_done); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL clamp_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_triangle();
    int n;
    logic [7:0] e;
    sb.delete();
    sb.push_back(8'd10); sb.push_back(8'd20); sb.push_back(8'd30); sb.push_back(8'd20);
    sb.push_back(8'd10); sb.push_back(8'd20); sb.push_back(8'd30);
    do_start(2'b10, 8'd10, 8'd30, 8'd10, 16'd1);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); n++;
      checks++;
      if (!ftw_valid || ftw_out !== sb[0]) begin
        errors++; $display("FAIL tri_ftw n=%0d got=%0d valid=%b exp=%0d", n, ftw_out, ftw_valid, sb[0]);
      end
      e = sb.pop_front();
    end
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || dds_en !== 1'b0) begin
      errors++; $display("FAIL tri_stop done=%b busy=%b en=%b exp=1/0/0", done, busy, dds_en);
    end
    checks++; if (ftw_out !== 8'd30) begin errors++; $display("FAIL tri_hold got=%0d exp=30", ftw_out); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL tri_done_width got=%b exp=0", done); end
  endtask

  task automatic test_continuous_err();
    int n;
    logic [7:0] e, last;
    sb.delete();
    sb.push_back(8'd10); sb.push_back(8'd20); sb.push_back(8'd30); sb.push_back(8'd10);
    sb.push_back(8'd20); sb.push_back(8'd30); sb.push_back(8'd10);
    do_start(2'b01, 8'd10, 8'd30, 8'd10, 16'd2);
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk); n++;
      if (ftw_valid) begin
        e = sb.pop_front();
        checks++; if (ftw_out !== e) begin errors++; $display("FAIL cont_ftw got=%0d exp=%0d", ftw_out, e); end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL cont_timeout left=%0d exp=0", sb.size()); end
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL cont_stop done=%b busy=%b exp=1/0", done, busy); end
    @(negedge clk);
    last = ftw_out;
    do_start(2'b01, 8'd50, 8'd40, 8'd5, 16'd1);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", err); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || ftw_valid !== 1'b0) begin
      errors++; $display("FAIL err_side busy=%b done=%b valid=%b exp=0/0/0", busy, done, ftw_valid);
    end
    checks++; if (ftw_out !== last) begin errors++; $display("FAIL err_ftw got=%0d exp=%0d", ftw_out, last); end
    @(negedge clk);
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_width err=%b busy=%b exp=0/0", err, busy); end
  endtask

  task automatic test_edge_configs();
    logic [7:0] e;
    sb.delete();
    sb.push_back(8'd10); sb.push_back(8'd20); sb.push_back(8'd30);
    do_start(2'b11, 8'd10, 8'd30, 8'd10, 16'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        checks++;
        if (!ftw_valid) begin errors++; $display("FAIL dw0_valid c=%0d got=0 exp=1", c); end
        else begin
          e = sb.pop_front();
          if (ftw_out !== e) begin errors++; $display("FAIL dw0_ftw c=%0d got=%0d exp=%0d", c, ftw_out, e); end
        end
      end else begin
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dw0_done done=%b busy=%b exp=1/0", done, busy); end
      end
    end
    @(negedge clk);
    do_start(2'b00, 8'd25, 8'd60, 8'd0, 16'd1);
    @(negedge clk);
    checks++; if (ftw_out !== 8'd25 || ftw_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL step0_first ftw=%0d valid=%b busy=%b exp=25/1/1", ftw_out, ftw_valid, busy);
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || dds_en !== 1'b0 || ftw_out !== 8'd25) begin
      errors++; $display("FAIL step0_done done=%b en=%b ftw=%0d exp=1/0/25", done, dds_en, ftw_out);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    bit seen_done;
    logic [7:0] e;
    @(negedge clk);
    do_start(2'b00, 8'd10, 8'd40, 8'd10, 16'd3);
    n = 0;
    while (ftw_out !== 8'd20 && n < 20) begin
      @(negedge clk); n++;
    end
    checks++; if (ftw_out !== 8'd20) begin errors++; $display("FAIL rst_reach20 got=%0d exp=20", ftw_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ftw_out !== 8'd0 || dds_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_async ftw=%0d en=%b busy=%b done=%b exp=0/0/0/0", ftw_out, dds_en, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_nodone c=%0d done=%b busy=%b exp=0/0", c, done, busy); end
    end
    sb.delete();
    sb.push_back(8'd10); sb.push_back(8'd20); sb.push_back(8'd30);
    do_start(2'b00, 8'd10, 8'd30, 8'd10, 16'd1);
    n = 0; seen_done = 1'b0;
    while (!seen_done && n < 20) begin
      @(negedge clk); n++;
      if (ftw_valid) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rst_resweep_extra got=%0d exp=none", ftw_out); end
        else begin
          e = sb.pop_front();
          if (ftw_out !== e) begin errors++; $display("FAIL rst_resweep got=%0d exp=%0d", ftw_out, e); end
        end
      end
      if (done) seen_done = 1'b1;
    end
    checks++; if (!seen_done || sb.size() != 0) begin
      errors++; $display("FAIL rst_resweep_end done=%b left=%0d exp=1/0", seen_done, sb.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_clamp();
    test_triangle();
    test_continuous_err();
    test_edge_configs();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer for the DDS block. It drives the DDS frequency tuning word (FTW) and enable.
- Steps the FTW from a start to a stop value in fixed increments.
- Holds each value for a programmable dwell time.
- Supports single, continuous-wrap and triangle (up/down) sweeps.
- Sits between the lab control logic (switches/registers) and the DDS phase-accumulator input.

Parameters:
FTW_W, 8, width of tuning word and all frequency config inputs
DWELL_W, 16, width of dwell-count input

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle request; latches config and starts sweep (IDLE only)
stop_req  in  1  abort running sweep
mode  in  2  00 single up, 01 continuous wrap, 10 triangle, 11 treated as 00
f_start  in  FTW_W  first tuning word
f_stop  in  FTW_W  last tuning word (inclusive)
f_step  in  FTW_W  increment per step
dwell  in  DWELL_W  clk cycles per frequency; 0 treated as 1
ftw_out  out  FTW_W  tuning word to DDS
dds_en  out  1  DDS accumulate enable
ftw_valid  out  1  one-cycle pulse whenever ftw_out takes a new value
busy  out  1  high while sweeping
done  out  1  one-cycle pulse at sweep end or abort
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (rst=0, asynchronous, any state): ftw_out=0, dds_en=0, ftw_valid=0, busy=0, done=0, err=0. Direction register = up, state = IDLE. Sweep abandoned; no done pulse.
- States: IDLE, RUN, FINISH.
- IDLE + start, config valid (f_start <= f_stop):
  - All config inputs latched at that edge; later input changes are ignored until the next start.
  - Next cycle: RUN, ftw_out=f_start, dds_en=1, busy=1, ftw_valid=1.
- IDLE + start, f_start > f_stop: err=1 for one cycle; stay IDLE; all other outputs unchanged.
- stop_req in IDLE is ignored.
- RUN:
  - Dwell counter reloads on every new FTW; each FTW is held exactly max(dwell,1) cycles.
  - At dwell expiry, compute next on FTW_W+1 bits.
- Up direction: next = ftw + step.
  - If next > f_stop, or ftw already equals f_stop, the endpoint is reached.
  - If next > f_stop but ftw < f_stop: the step is clamped to f_stop.
- Endpoint handling when ftw==f_stop at dwell expiry:
  - Single: go to FINISH.
  - Continuous: ftw = f_start.
  - Triangle: direction = down; next computed as below.
- Down direction (triangle only): next = ftw - step.
  - Underflow or result < f_start clamps to f_start.
  - At f_start, direction = up; the following step goes upward.
  - The endpoints f_start and f_stop are each dwelt once per turn, never twice.
- ftw_valid pulses in the cycle ftw_out changes value. No pulse if the computed value equals the current one (step=0).
- f_step=0:
  - Single: FINISH after the first dwell.
  - Continuous/triangle: hold f_start until stop_req.
- FINISH (one cycle): done=1, busy=0, dds_en=0, ftw_out holds its last value. Then IDLE.
- stop_req in RUN: next cycle is FINISH-equivalent (done=1, dds_en=0, busy=0), then IDLE. stop_req has priority over a same-cycle dwell expiry.
- start while busy: ignored, no err.
- done and err are never asserted in the same cycle.

Decomposition:
- Package dds_ctrl_pkg:
  - state enum {IDLE, RUN, FINISH}
  - mode constants MODE_SINGLE=2'b00, MODE_CONT=2'b01, MODE_TRI=2'b10
  - direction constants DIR_UP/DIR_DOWN
- Sub-module dds_dwell_timer(clk, rst, load, dwell, expire): loadable down-counter.
  - load presets the count to max(dwell,1).
  - expire is high in the last cycle of the dwell.
- FTW arithmetic and FSM stay in dds_sweep_ctrl.

Test Plan:
- Single sweep: mode=00, f_start=10, f_stop=40, f_step=10, dwell=3, start pulse at edge k. Required response:
  - ftw_out = 10,20,30,40, each for 3 cycles, starting at k+1.
  - ftw_valid pulses at k+1, k+4, k+7, k+10.
  - done at k+13; dds_en=0 from k+13; ftw_out stays 40.
- Clamp: f_start=10, f_stop=35, f_step=10, dwell=1, mode=00 -> ftw_out = 10,20,30,35, then done; no value above 35 ever appears.
- Triangle: f_start=10, f_stop=30, f_step=10, dwell=1, mode=10 -> ftw_out = 10,20,30,20,10,20,30; stop_req after 7 values -> done next cycle, busy=0.
- Continuous plus error:
  - mode=01, 10->30 step 10 -> ftw_out = 10,20,30,10,20...
  - Separate start with f_start=50, f_stop=40 -> err single pulse, busy stays 0, ftw_out unchanged.
- Edge configs:
  - dwell=0 behaves identically to dwell=1.
  - f_step=0 with mode=00 -> ftw_out=f_start for one cycle, then done.
- Reset mid-run: rst low between edges during the 20 dwell -> ftw_out=0, dds_en=0, busy=0 immediately, no done pulse. After release, a new start sweeps normally from f_start.
